// File: rtl/r2b_converter_pp.sv
// Row-to-block converter: two ping-pong slice banks fill with full matrix rows
// and drain as BLOCK_SIZE-wide column groups, optionally transposed per block.
module r2b_converter_pp #(
  parameter int WIDTH       = 16,
  parameter int BLOCK_SIZE  = 2,
  parameter int COL         = 256,
  parameter int ROW         = 2754,
  parameter int NUM_CORES_V = 2
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          en,
  input  logic                                          transpose,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [WIDTH*COL-1:0]                          in_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE*NUM_CORES_V-1:0] out_data,
  output logic                                          slice_done,
  output logic                                          slice_last,
  output logic                                          frame_done
);

  localparam int SLICE_ROWS = BLOCK_SIZE * NUM_CORES_V;
  localparam int BEATS      = COL / BLOCK_SIZE;
  localparam int SLICES     = ROW / SLICE_ROWS;
  localparam int ROW_W      = (SLICE_ROWS > 1) ? $clog2(SLICE_ROWS) : 1;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLICE_W    = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int OUT_W      = WIDTH * BLOCK_SIZE * SLICE_ROWS;

  logic [WIDTH*COL-1:0] bank_q [2][SLICE_ROWS];

  logic [1:0]         full_q, full_d;
  logic [1:0]         mode_q, mode_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [ROW_W-1:0]   wr_row_q, wr_row_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [SLICE_W-1:0] slice_q, slice_d;
  logic               frame_done_q, frame_done_d;

  logic wr_fire, rd_fire, last_row, last_beat, last_slice;

  assign in_ready   = rst_n && en && !full_q[wr_bank_q];
  assign out_valid  = rst_n && en && full_q[rd_bank_q];
  assign wr_fire    = in_valid && in_ready;
  assign rd_fire    = out_valid && out_ready;
  assign last_row   = (wr_row_q == ROW_W'(SLICE_ROWS - 1));
  assign last_beat  = (beat_q == BEAT_W'(BEATS - 1));
  assign last_slice = (slice_q == SLICE_W'(SLICES - 1));
  assign slice_done = out_valid && last_beat;
  assign slice_last = slice_done && last_slice;
  assign frame_done = frame_done_q;

  // NOTE: next-state logic uses blocking '=' with every _d defaulted to its _q
  // first, so no latches form; the flops below take _d with non-blocking '<='.
  always_comb begin
    full_d       = full_q;
    mode_d       = mode_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_row_d     = wr_row_q;
    beat_d       = beat_q;
    slice_d      = slice_q;
    frame_done_d = rd_fire && slice_last;

    if (wr_fire) begin
      if (wr_row_q == '0) mode_d[wr_bank_q] = transpose;
      if (last_row) begin
        full_d[wr_bank_q] = 1'b1;
        wr_row_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end

    // Fill and drain complete on different banks, so both updates can land together.
    if (rd_fire) begin
      if (last_beat) begin
        beat_d            = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        slice_d           = last_slice ? '0 : slice_q + 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q       <= '0;
      mode_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_row_q     <= '0;
      beat_q       <= '0;
      slice_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      full_q       <= full_d;
      mode_q       <= mode_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_row_q     <= wr_row_d;
      beat_q       <= beat_d;
      slice_q      <= slice_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: bank storage has no reset; the full flags alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) bank_q[wr_bank_q][wr_row_q] <= in_data;
  end

  int                   src_row, src_col;
  logic [WIDTH*COL-1:0] src_data;
  logic [WIDTH-1:0]     elem;
  logic [OUT_W-1:0]     out_acc;

  // Segment s, slot q; in transpose mode the block's row and column swap roles.
  always_comb begin
    src_row  = 0;
    src_col  = 0;
    src_data = '0;
    elem     = '0;
    out_acc  = '0;
    for (int s = 0; s < SLICE_ROWS; s++) begin
      for (int q = 0; q < BLOCK_SIZE; q++) begin
        if (mode_q[rd_bank_q]) begin
          src_row = (s / BLOCK_SIZE) * BLOCK_SIZE + q;
          src_col = int'(beat_q) * BLOCK_SIZE + (s % BLOCK_SIZE);
        end else begin
          src_row = s;
          src_col = int'(beat_q) * BLOCK_SIZE + q;
        end
        src_data = bank_q[rd_bank_q][ROW_W'(src_row)];
        elem     = WIDTH'(src_data >> ((COL - 1 - src_col) * WIDTH));
        out_acc  = (out_acc << WIDTH) | OUT_W'(elem);
      end
    end
  end

  assign out_data = out_acc;

endmodule
